div_unit: RTL and testbench

- Multi-cycle 32-bit radix-2 restoring divider. Serves the EX stage and takes its operands from the ID/EX pipeline register outputs (ex_reg1 = dividend, ex_reg2 = divisor).
- EX holds start_i high and raises a stall request until ready_o is seen. The 64-bit result goes to HI/LO via EX/MEM as {remainder, quotient}.
- annul_i lets EX abandon a division, e.g. on a pipeline flush.

---
 rtl/div_unit.sv | 127 ++++++++++++
 tb/tb_div_unit.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for the EX stage: one quotient bit per clock,
// sign fix-up on the final step, result held in END until the requester drops start_i.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 signed_div_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  input  logic                 start_i,
  input  logic                 annul_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {FREE, BY_ZERO, ON, END} state_t;

  state_t           state, state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd;        // dividend bits shift out the top, quotient bits enter at the bottom
  logic [WIDTH-1:0] dsr;
  logic [WIDTH-1:0] rem;
  logic             neg_q, neg_r;

  logic [WIDTH:0]   trial, diff;
  logic             ge;
  logic [WIDTH-1:0] rem_step, quo_step, quo_fix, rem_fix;
  logic [WIDTH-1:0] abs1, abs2;
  logic             last_step;

  always_comb begin
    trial     = {rem, dvd[WIDTH-1]};
    diff      = trial - {1'b0, dsr};
    ge        = ~diff[WIDTH];
    rem_step  = ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    quo_step  = {dvd[WIDTH-2:0], ge};
    quo_fix   = neg_q ? (~quo_step + 1'b1) : quo_step;
    rem_fix   = neg_r ? (~rem_step + 1'b1) : rem_step;
    abs1      = (signed_div_i && opdata1_i[WIDTH-1]) ? (~opdata1_i + 1'b1) : opdata1_i;
    abs2      = (signed_div_i && opdata2_i[WIDTH-1]) ? (~opdata2_i + 1'b1) : opdata2_i;
    last_step = (cnt == CW'(WIDTH - 1));
  end

  always_comb begin
    state_next = state;
    case (state)
      FREE: begin
        if (start_i && !annul_i)
          state_next = (opdata2_i == '0) ? BY_ZERO : ON;
      end
      BY_ZERO: state_next = annul_i ? FREE : END;
      ON: begin
        if (annul_i || !start_i) state_next = FREE;
        else if (last_step)      state_next = END;
      end
      END: begin
        if (annul_i || !start_i) state_next = FREE;
      end
      default: state_next = FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= FREE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ready_o  <= 1'b0;
      result_o <= '0;
      cnt      <= '0;
      dvd      <= '0;
      dsr      <= '0;
      rem      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
    end else begin
      case (state)
        FREE: begin
          ready_o  <= 1'b0;
          result_o <= '0;
          if (start_i && !annul_i) begin
            dvd   <= abs1;
            dsr   <= abs2;
            rem   <= '0;
            cnt   <= '0;
            neg_r <= signed_div_i & opdata1_i[WIDTH-1];
            neg_q <= signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
          end
        end
        BY_ZERO: begin
          result_o <= '0;
          ready_o  <= !annul_i;
        end
        ON: begin
          if (annul_i || !start_i) begin
            ready_o  <= 1'b0;
            result_o <= '0;
          end else begin
            rem <= rem_step;
            dvd <= quo_step;
            cnt <= cnt + 1'b1;
            if (last_step) begin
              result_o <= {rem_fix, quo_fix};
              ready_o  <= 1'b1;
            end
          end
        end
        END: begin
          if (annul_i || !start_i) begin
            ready_o  <= 1'b0;
            result_o <= '0;
          end
        end
        default: begin
          ready_o  <= 1'b0;
          result_o <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus random operations,
// compared against plain integer division with MIPS remainder-sign semantics.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i, opdata2_i;
  logic        start_i, annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int vectors = 0;
  int miscompares = 0;

  div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .signed_div_i(signed_div_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
    .start_i(start_i), .annul_i(annul_i),
    .result_o(result_o), .ready_o(ready_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input bit sgn);
    longint sa, sb, q, r;
    int ia, ib;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      ia = a; ib = b;
      sa = ia; sb = ib;
    end else begin
      sa = {32'd0, a}; sb = {32'd0, b};
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run one operation: count edges until ready, check result, hold start in END,
  // then drop start and check the outputs clear on the next edge.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit sgn,
                        input int hold, input bit toggle);
    int n;
    logic [63:0] exp;
    logic [63:0] first;
    exp = model(a, b, sgn);
    opdata1_i    = a;
    opdata2_i    = b;
    signed_div_i = sgn;
    start_i      = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
      if (toggle) begin
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = 1'($urandom_range(0, 1));
      end
    end while (!ready_o && n < 100);
    chk("latency", 64'(n), (b == 32'd0) ? 64'd2 : 64'd33);
    chk("result", result_o, exp);
    first = result_o;
    for (int k = 0; k < hold; k++) begin
      tick();
      chk("hold_ready", 64'(ready_o), 64'd1);
      chk("hold_result", result_o, first);
    end
    start_i = 1'b0;
    tick();
    chk("drop_ready", 64'(ready_o), 64'd0);
    chk("drop_result", result_o, 64'd0);
  endtask

  initial begin
    logic [31:0] a, b;
    bit sgn;
    rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0;
    tick(); tick();
    chk("reset_ready", 64'(ready_o), 64'd0);
    chk("reset_result", result_o, 64'd0);
    rst = 1'b0;
    tick();

    run_op(32'd100, 32'd7, 1'b0, 0, 1'b0);
    run_op(32'hFFFFFFF9, 32'h2, 1'b1, 0, 1'b0);
    run_op(32'h80000000, 32'hFFFFFFFF, 1'b1, 0, 1'b0);
    run_op(32'd7, 32'hFFFFFFFE, 1'b1, 0, 1'b0);
    run_op(32'h12345678, 32'h0, 1'b0, 0, 1'b0);

    // annul and start together in FREE: nothing is accepted
    start_i = 1'b1; annul_i = 1'b1; opdata1_i = 32'd50; opdata2_i = 32'd5;
    for (int k = 0; k < 3; k++) tick();
    annul_i = 1'b0; start_i = 1'b0;
    for (int k = 0; k < 35; k++) tick();
    chk("annul_start_ready", 64'(ready_o), 64'd0);

    // annul pulsed on the 10th ON cycle
    opdata1_i = 32'd1000; opdata2_i = 32'd3; signed_div_i = 1'b0; start_i = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    annul_i = 1'b1;
    tick();
    annul_i = 1'b0; start_i = 1'b0;
    chk("annul_ready", 64'(ready_o), 64'd0);
    chk("annul_result", result_o, 64'd0);
    begin
      int seen = 0;
      for (int k = 0; k < 40; k++) begin
        tick();
        if (ready_o) seen++;
      end
      chk("annul_never_ready", 64'(seen), 64'd0);
    end
    run_op(32'hFFFFFFFF, 32'h10, 1'b0, 0, 1'b0);

    // reset mid-ON
    opdata1_i = 32'hDEADBEEF; opdata2_i = 32'd9; signed_div_i = 1'b0; start_i = 1'b1;
    for (int k = 0; k < 15; k++) tick();
    rst = 1'b1;
    tick();
    chk("rst_mid_ready", 64'(ready_o), 64'd0);
    chk("rst_mid_result", result_o, 64'd0);
    rst = 1'b0; start_i = 1'b0;
    tick();

    // back-to-back with hold in END, then operand toggling during ON
    run_op(32'd123456, 32'd789, 1'b0, 5, 1'b0);
    run_op(32'hFFFF0000, 32'd77, 1'b1, 0, 1'b0);
    run_op(32'hCAFEBABE, 32'h1234, 1'b0, 2, 1'b1);

    for (int i = 0; i < 25; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'($urandom_range(1, 255));
        1: b = $urandom;
        2: b = (i % 5 == 0) ? 32'd0 : 32'hFFFFFFFF - 32'($urandom_range(0, 3));
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      sgn = 1'($urandom_range(0, 1));
      run_op(a, b, sgn, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
